// File: rtl/iir_sos_sequencer.sv
// Sequencer for a time-multiplexed cascade of IIR second-order sections.
// Optional sticky datapath-overflow tracking is built when IIR_SEQ_OVF_EN is defined.
module iir_sos_sequencer #(
  parameter int unsigned NO_SOS = 4,
  parameter int unsigned WX     = 10,
  parameter int unsigned WY     = 26,
  parameter int unsigned IDXW   = 2
) (
  input  logic            CLK_en,
  input  logic            RESET,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WX-1:0]   in_data,
  output logic [WX-1:0]   smp_data,
  output logic [IDXW-1:0] sos_idx,
  output logic            sel_ext,
  output logic            stage_en,
  input  logic [WY-1:0]   dp_result,
  input  logic            dp_overflow,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WY-1:0]   out_data,
  output logic            out_overflow,
  output logic            busy
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NO_SOS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_cnt;
  logic [IDXW-1:0] w_cnt_nxt;
  logic [WX-1:0]   r_smp;
  logic [WX-1:0]   w_smp_nxt;
  logic [WY-1:0]   r_out_data;
  logic [WY-1:0]   w_out_data_nxt;
  logic            r_out_valid;
  logic            w_out_valid_nxt;
  logic            w_capture;
  logic            w_accept;
  logic            w_run;

  assign w_run = (r_state == ST_RUN);

  // Control outputs decode the current state and are forced quiet while reset is held.
  assign in_ready = RESET && (r_state == ST_IDLE);
  assign busy     = RESET && (r_state != ST_IDLE);
  assign stage_en = RESET && w_run;
  assign sel_ext  = !RESET || (r_cnt == IDXW'(0));

  assign sos_idx   = r_cnt;
  assign smp_data  = r_smp;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  // Next-state and next-register logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_smp_nxt       = r_smp;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid && !out_ready;
    w_capture       = 1'b0;
    w_accept        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_smp_nxt   = in_data;
          w_cnt_nxt   = IDXW'(0);
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt != LAST_IDX) begin
          w_cnt_nxt = r_cnt + IDXW'(1);
        end else if (!r_out_valid || out_ready) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = IDXW'(0);
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = IDXW'(0);
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = IDXW'(0);
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_capture) begin
      w_out_data_nxt  = dp_result;
      w_out_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK_en) begin
    if (!RESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= IDXW'(0);
      r_smp       <= WX'(0);
      r_out_data  <= WY'(0);
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_smp       <= w_smp_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

`ifdef IIR_SEQ_OVF_EN
  logic r_sticky;
  logic r_out_ovf;
  logic w_sticky_acc;

  // The last section's overflow arrives in the capture cycle itself, so fold it in before copying.
  assign w_sticky_acc = r_sticky || (w_run && dp_overflow);
  assign out_overflow = r_out_ovf;

  always_ff @(posedge CLK_en) begin
    if (!RESET) begin
      r_sticky  <= 1'b0;
      r_out_ovf <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sticky <= 1'b0;
      end else begin
        r_sticky <= w_sticky_acc;
      end
      if (w_capture) begin
        r_out_ovf <= w_sticky_acc;
      end
    end
  end
`else
  logic w_unused_ovf;

  assign w_unused_ovf = dp_overflow ^ w_accept;
  assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Directed bench for iir_sos_sequencer: cycle table on a 4-section instance,
// plus a back-to-back streaming sequence on a single-section instance.
module tb_iir_sos_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, sel_ext, stage_en, dp_overflow;
  logic        out_valid, out_ready, out_overflow, busy;
  logic [9:0]  in_data, smp_data;
  logic [1:0]  sos_idx;
  logic [25:0] dp_result, out_data;

  logic        in_valid1, in_ready1, sel_ext1, stage_en1, dp_overflow1;
  logic        out_valid1, out_ready1, out_overflow1, busy1;
  logic [9:0]  in_data1, smp_data1;
  logic [0:0]  sos_idx1;
  logic [25:0] dp_result1, out_data1;

  iir_sos_sequencer #(.NO_SOS(4), .WX(10), .WY(26), .IDXW(2)) u_dut (
    .CLK_en(clk), .RESET(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .smp_data(smp_data), .sos_idx(sos_idx), .sel_ext(sel_ext), .stage_en(stage_en),
    .dp_result(dp_result), .dp_overflow(dp_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_overflow(out_overflow), .busy(busy)
  );

  iir_sos_sequencer #(.NO_SOS(1), .WX(10), .WY(26), .IDXW(1)) u_dut1 (
    .CLK_en(clk), .RESET(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .smp_data(smp_data1), .sos_idx(sos_idx1), .sel_ext(sel_ext1), .stage_en(stage_en1),
    .dp_result(dp_result1), .dp_overflow(dp_overflow1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .out_overflow(out_overflow1), .busy(busy1)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [9:0]  idata;
    logic        ordy;
    logic [25:0] dpr;
    logic        dpo;
    logic        e_ir;
    logic        e_busy;
    logic        e_se;
    logic        e_sx;
    logic [1:0]  e_idx;
    logic [9:0]  e_smp;
    logic        e_ov;
    logic [25:0] e_od;
    logic        e_oo;   // expected out_overflow when the overflow option is built
  } vec_t;

  vec_t tbl [21];
  int   n_vec = 0;
  int   n_bad = 0;

  initial begin
    // Inputs are applied, outputs checked before the next rising edge (state from the previous edge).
    tbl[0]  = '{1'b0, 1'b1, 10'h3FF, 1'b1, 26'h0000000, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 1'b0, 26'h0000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 10'h040, 1'b1, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 1'b0, 26'h0000000, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 10'h155, 1'b1, 26'h00000A1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 10'h040, 1'b0, 26'h0000000, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 10'h2AA, 1'b1, 26'h00000A2, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 10'h040, 1'b0, 26'h0000000, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 10'h111, 1'b1, 26'h00000A3, 1'b1,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 10'h040, 1'b0, 26'h0000000, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h1234567, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 10'h040, 1'b0, 26'h0000000, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 10'h080, 1'b0, 26'h00000B1, 1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h040, 1'b1, 26'h1234567, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 10'h000, 1'b0, 26'h00000B2, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 10'h000, 1'b0, 26'h00000B3, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 10'h000, 1'b0, 26'h00000B4, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 10'h000, 1'b0, 26'h2ABCDEF, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 10'h3C3, 1'b0, 26'h2ABCDEF, 1'b1,  1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h2ABCDEF, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 10'h080, 1'b1, 26'h1234567, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 10'h000, 1'b0, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h080, 1'b1, 26'h2ABCDEF, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h080, 1'b1, 26'h2ABCDEF, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 10'h07F, 1'b1, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h080, 1'b0, 26'h2ABCDEF, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h00000C1, 1'b0,  1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 10'h07F, 1'b0, 26'h2ABCDEF, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h00000C2, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 10'h07F, 1'b0, 26'h2ABCDEF, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 10'h000, 1'b1, 26'h00000C3, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 10'h07F, 1'b0, 26'h2ABCDEF, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 1'b0, 26'h0000000, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 10'h000, 1'b1, 26'h0000000, 1'b0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h000, 1'b0, 26'h0000000, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;  in_data = 10'h000;  out_ready = 1'b1;
    dp_result = 26'h0;  dp_overflow = 1'b0;
    in_valid1 = 1'b0; in_data1 = 10'h000; out_ready1 = 1'b1;
    dp_result1 = 26'h0; dp_overflow1 = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 21; i++) begin
      logic exp_oo;
      @(negedge clk);
      rst_n       = tbl[i].rst;
      in_valid    = tbl[i].iv;
      in_data     = tbl[i].idata;
      out_ready   = tbl[i].ordy;
      dp_result   = tbl[i].dpr;
      dp_overflow = tbl[i].dpo;
      #1;
`ifdef IIR_SEQ_OVF_EN
      exp_oo = tbl[i].e_oo;
`else
      exp_oo = 1'b0;
`endif
      n_vec++;
      if (in_ready !== tbl[i].e_ir || busy !== tbl[i].e_busy || stage_en !== tbl[i].e_se ||
          sel_ext !== tbl[i].e_sx || sos_idx !== tbl[i].e_idx || smp_data !== tbl[i].e_smp ||
          out_valid !== tbl[i].e_ov || out_data !== tbl[i].e_od || out_overflow !== exp_oo) begin
        n_bad++;
        $display("FAIL vec%0d: got ir=%b busy=%b se=%b sx=%b idx=%0d smp=%h ov=%b od=%h oo=%b, want ir=%b busy=%b se=%b sx=%b idx=%0d smp=%h ov=%b od=%h oo=%b",
                 i, in_ready, busy, stage_en, sel_ext, sos_idx, smp_data, out_valid, out_data, out_overflow,
                 tbl[i].e_ir, tbl[i].e_busy, tbl[i].e_se, tbl[i].e_sx, tbl[i].e_idx, tbl[i].e_smp,
                 tbl[i].e_ov, tbl[i].e_od, exp_oo);
      end
    end

    // Single-section instance streaming with in_valid and out_ready held high.
    begin
      logic [25:0] mdl_od;
      logic [9:0]  mdl_smp;
      mdl_od  = 26'h0;
      mdl_smp = 10'h000;
      for (int c = 0; c < 10; c++) begin
        logic odd, e_ov;
        @(negedge clk);
        in_valid1  = 1'b1;
        in_data1   = 10'(c + 5);
        dp_result1 = 26'(c * 7 + 3);
        #1;
        odd  = (c % 2) == 1;
        e_ov = (c >= 2) && !odd;
        n_vec++;
        if (in_ready1 !== !odd || busy1 !== odd || stage_en1 !== odd || sel_ext1 !== 1'b1 ||
            sos_idx1 !== 1'b0 || smp_data1 !== mdl_smp || out_valid1 !== e_ov ||
            out_data1 !== mdl_od || out_overflow1 !== 1'b0) begin
          n_bad++;
          $display("FAIL sos1_cyc%0d: got ir=%b busy=%b se=%b sx=%b idx=%0d smp=%h ov=%b od=%h oo=%b, want ir=%b busy=%b se=%b sx=1 idx=0 smp=%h ov=%b od=%h oo=0",
                   c, in_ready1, busy1, stage_en1, sel_ext1, sos_idx1, smp_data1, out_valid1, out_data1,
                   out_overflow1, !odd, odd, odd, mdl_smp, e_ov, mdl_od);
        end
        if (odd) mdl_od = dp_result1;
        else     mdl_smp = in_data1;
      end
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
